// File: rtl/processor_controller_pkg.sv
// Shared definitions for the debug/boot controller: host command opcodes,
// the acknowledge byte and the command FSM state encoding.
package processor_controller_pkg;

    localparam logic [7:0] CMD_RESET = 8'h52;
    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_STOP  = 8'h50;
    localparam logic [7:0] CMD_STEP  = 8'h43;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_ID    = 8'h49;
    localparam logic [7:0] ACK_BYTE  = 8'h06;

    typedef enum logic [2:0] {IDLE, ARGS, EXEC, STEP, RESP} state_t;

endpackage

// File: rtl/processor_controller_uart_phy.sv
// 8N1 UART: synchronized receiver with mid-bit sampling, and a transmitter
// fed from a small byte FIFO.
module processor_controller_uart_phy #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PAYLOAD_BITS = 8,
    parameter int BUFFER_SIZE  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    output logic                    tx,
    output logic [PAYLOAD_BITS-1:0] rx_data,
    output logic                    rx_valid,
    input  logic [PAYLOAD_BITS-1:0] tx_data,
    input  logic                    tx_push,
    output logic                    tx_full
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(PAYLOAD_BITS + 2);
    localparam int PW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int FW = $clog2(BUFFER_SIZE + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t               rx_state;
    logic [1:0]              rx_sync;
    logic [CW-1:0]           rx_cnt;
    logic [BW-1:0]           rx_bit;
    logic [PAYLOAD_BITS-1:0] rx_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_valid <= 1'b0;
            rx_cnt   <= rx_cnt + 1'b1;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync[1]) rx_state <= RX_START;
                end
                // Re-check the start bit at half a bit so later samples land mid-bit
                RX_START: if (rx_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_sync[1] ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_sync[1], rx_shift[PAYLOAD_BITS-1:1]};
                    rx_bit   <= rx_bit + 1'b1;
                    if (rx_bit == BW'(PAYLOAD_BITS - 1)) rx_state <= RX_STOP;
                end
                RX_STOP: if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    rx_state <= RX_IDLE;
                    if (rx_sync[1]) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    logic [PAYLOAD_BITS-1:0] fifo [BUFFER_SIZE];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [FW-1:0]           count;
    logic                    tx_busy, tx_pop, tx_wr;
    logic [CW-1:0]           tx_cnt;
    logic [BW-1:0]           tx_left;
    logic [PAYLOAD_BITS:0]   tx_shift;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUFFER_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    assign tx_full = (count == FW'(BUFFER_SIZE));
    assign tx_wr   = tx_push && !tx_full;
    assign tx_pop  = !tx_busy && (count != '0);

    always_ff @(posedge clk)
        if (tx_wr) fifo[wr_ptr] <= tx_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_left  <= '0;
            tx_shift <= '1;
        end else begin
            if (tx_wr)  wr_ptr <= ptr_inc(wr_ptr);
            if (tx_pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + FW'(tx_wr) - FW'(tx_pop);
            if (tx_pop) begin
                // Start bit goes out now; data then stop bit follow from the shifter
                tx       <= 1'b0;
                tx_shift <= {1'b1, fifo[rd_ptr]};
                tx_left  <= BW'(PAYLOAD_BITS + 1);
                tx_cnt   <= '0;
                tx_busy  <= 1'b1;
            end else if (tx_busy) begin
                if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    tx_cnt <= '0;
                    if (tx_left == '0) begin
                        tx_busy <= 1'b0;
                    end else begin
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b1, tx_shift[PAYLOAD_BITS:1]};
                        tx_left  <= tx_left - 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/processor_controller.sv
// Debug/boot controller: UART command interface, gated core clock, core reset
// pulse, and a unified memory shared by host and both core memory ports.
module processor_controller
    import processor_controller_pkg::*;
#(
    parameter int          CLK_FREQ           = 100000000,
    parameter int          BIT_RATE           = 115200,
    parameter int          PAYLOAD_BITS       = 8,
    parameter int          BUFFER_SIZE        = 8,
    parameter int          PULSE_CONTROL_BITS = 32,
    parameter int          BUS_WIDTH          = 32,
    parameter int          WORD_SIZE_BY       = 4,
    parameter int unsigned ID                 = 0,
    parameter int          RESET_CLK_CYCLES   = 20,
    parameter              MEMORY_FILE        = "",
    parameter int          MEMORY_SIZE        = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 sck,
    input  logic                 cs,
    input  logic                 mosi,
    output logic                 miso,
    input  logic                 rw,
    output logic                 intr,
    output logic                 clk_core,
    output logic                 reset_core,
    input  logic                 core_read_memory,
    input  logic                 core_write_memory,
    input  logic [BUS_WIDTH-1:0] core_address_memory,
    input  logic [BUS_WIDTH-1:0] core_write_data_memory,
    output logic [BUS_WIDTH-1:0] core_read_data_memory,
    output logic                 core_memory_response,
    output logic [BUS_WIDTH-1:0] core_read_data_memory_sync,
    output logic                 core_memory_read_response_sync,
    output logic                 core_memory_write_response_sync,
    input  logic                 core_read_memory_data,
    input  logic                 core_write_memory_data,
    input  logic [BUS_WIDTH-1:0] core_address_memory_data,
    input  logic [BUS_WIDTH-1:0] core_write_data_memory_data,
    output logic [BUS_WIDTH-1:0] core_read_data_memory_data,
    output logic                 core_memory_response_data
);
    localparam int AW    = $clog2(MEMORY_SIZE);
    localparam int OB    = $clog2(WORD_SIZE_BY);
    localparam int WORDS = MEMORY_SIZE / WORD_SIZE_BY;
    localparam int RW    = $clog2(RESET_CLK_CYCLES + 1);

    state_t                        state;
    logic [7:0]                    opcode, rx_byte;
    logic [63:0]                   args;
    logic [3:0]                    arg_cnt;
    logic [31:0]                   resp;
    logic [2:0]                    resp_cnt;
    logic                          rx_pend, rx_take, run, clk_en, core_stopped, host_we;
    logic [PULSE_CONTROL_BITS-1:0] step_cnt;
    logic [RW-1:0]                 rst_cnt;
    logic [31:0]                   host_addr;
    logic [AW-OB-1:0]              host_idx, i_idx, d_idx;
    logic [PAYLOAD_BITS-1:0]       rx_data, tx_data;
    logic                          rx_valid, tx_push, tx_full;
    logic [BUS_WIDTH-1:0]          mem [WORDS];

    processor_controller_uart_phy #(
        .CLKS_PER_BIT(CLK_FREQ / BIT_RATE),
        .PAYLOAD_BITS(PAYLOAD_BITS),
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_uart (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full)
    );

    assign miso = 1'b0;
    assign intr = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{sck, cs, mosi, rw, (MEMORY_FILE != ""),
                         core_address_memory[BUS_WIDTH-1:AW], core_address_memory[OB-1:0],
                         core_address_memory_data[BUS_WIDTH-1:AW], core_address_memory_data[OB-1:0],
                         host_addr[31:AW], host_addr[OB-1:0]};

    assign host_addr    = (opcode == CMD_WRITE) ? args[63:32] : args[31:0];
    assign host_idx     = host_addr[AW-1:OB];
    assign i_idx        = core_address_memory[AW-1:OB];
    assign d_idx        = core_address_memory_data[AW-1:OB];
    assign core_stopped = !clk_en && !run;
    assign host_we      = (state == EXEC) && (opcode == CMD_WRITE) && core_stopped;
    assign rx_take      = rx_pend && (state == IDLE || state == ARGS);
    assign tx_push      = (state == RESP) && !tx_full;
    assign tx_data      = PAYLOAD_BITS'(resp[31:24]);

    // Enable changes only while clk is low, so clk_core pulses are always full-width
    always_ff @(negedge clk or posedge reset)
        if (reset) clk_en <= 1'b0;
        else       clk_en <= run || (step_cnt != '0);

    assign clk_core = clk & clk_en;

    // Data port is written last so it wins a same-word collision
    always_ff @(posedge clk) begin
        if (host_we) mem[host_idx] <= args[BUS_WIDTH-1:0];
        if (clk_en && core_write_memory)      mem[i_idx] <= core_write_data_memory;
        if (clk_en && core_write_memory_data) mem[d_idx] <= core_write_data_memory_data;
    end

    assign core_read_data_memory_sync      = mem[i_idx];
    assign core_memory_read_response_sync  = core_read_memory;
    assign core_memory_write_response_sync = core_write_memory;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_read_data_memory      <= '0;
            core_memory_response       <= 1'b0;
            core_read_data_memory_data <= '0;
            core_memory_response_data  <= 1'b0;
        end else begin
            core_memory_response      <= clk_en && (core_read_memory || core_write_memory);
            core_memory_response_data <= clk_en && (core_read_memory_data || core_write_memory_data);
            if (clk_en && core_read_memory)      core_read_data_memory      <= mem[i_idx];
            if (clk_en && core_read_memory_data) core_read_data_memory_data <= mem[d_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            opcode     <= '0;
            args       <= '0;
            arg_cnt    <= '0;
            resp       <= '0;
            resp_cnt   <= '0;
            rx_pend    <= 1'b0;
            rx_byte    <= '0;
            run        <= 1'b0;
            step_cnt   <= '0;
            rst_cnt    <= RW'(RESET_CLK_CYCLES);
            reset_core <= 1'b1;
        end else begin
            reset_core <= (rst_cnt != '0);
            if (rst_cnt != '0)  rst_cnt  <= rst_cnt - 1'b1;
            if (step_cnt != '0) step_cnt <= step_cnt - 1'b1;
            // One-byte holding register keeps a command until the FSM can take it
            if (rx_valid) begin
                rx_byte <= 8'(rx_data);
                rx_pend <= 1'b1;
            end else if (rx_take) begin
                rx_pend <= 1'b0;
            end
            case (state)
                IDLE: if (rx_take) begin
                    opcode  <= rx_byte;
                    arg_cnt <= 4'd4;
                    case (rx_byte)
                        CMD_RESET, CMD_START, CMD_STOP, CMD_ID: state <= EXEC;
                        CMD_STEP, CMD_LOAD: state <= ARGS;
                        CMD_WRITE: begin
                            arg_cnt <= 4'd8;
                            state   <= ARGS;
                        end
                        default: state <= IDLE;
                    endcase
                end
                ARGS: if (rx_take) begin
                    args    <= {args[55:0], rx_byte};
                    arg_cnt <= arg_cnt - 1'b1;
                    if (arg_cnt == 4'd1) state <= EXEC;
                end
                EXEC: begin
                    resp     <= {ACK_BYTE, 24'h0};
                    resp_cnt <= 3'd1;
                    state    <= RESP;
                    case (opcode)
                        CMD_RESET: rst_cnt <= RW'(RESET_CLK_CYCLES);
                        CMD_START: run <= 1'b1;
                        CMD_STOP:  run <= 1'b0;
                        CMD_STEP: begin
                            step_cnt <= PULSE_CONTROL_BITS'(args[31:0]);
                            state    <= STEP;
                        end
                        CMD_WRITE: if (!core_stopped) state <= EXEC;
                        CMD_LOAD:
                            if (core_stopped) begin
                                resp     <= 32'(mem[host_idx]);
                                resp_cnt <= 3'd4;
                            end else begin
                                state <= EXEC;
                            end
                        CMD_ID: begin
                            resp     <= 32'(ID);
                            resp_cnt <= 3'd4;
                        end
                        default: state <= IDLE;
                    endcase
                end
                STEP: if (step_cnt == '0) state <= RESP;
                RESP: if (!tx_full) begin
                    resp     <= resp << 8;
                    resp_cnt <= resp_cnt - 1'b1;
                    if (resp_cnt == 3'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_processor_controller.sv
// Scoreboard bench: host commands go in over rx, expected reply bytes are
// queued and compared as the tx monitor decodes frames.
module tb_processor_controller;
    logic        clk = 1'b0;
    logic        reset, rx, sck, cs, mosi, rw;
    logic        tx, miso, intr, clk_core, reset_core;
    logic        core_read_memory, core_write_memory;
    logic [31:0] core_address_memory, core_write_data_memory;
    logic [31:0] core_read_data_memory, core_read_data_memory_sync;
    logic        core_memory_response, core_memory_read_response_sync, core_memory_write_response_sync;
    logic        core_read_memory_data, core_write_memory_data;
    logic [31:0] core_address_memory_data, core_write_data_memory_data, core_read_data_memory_data;
    logic        core_memory_response_data;

    always #5 clk = ~clk;

    processor_controller #(
        .CLK_FREQ(1152000), .BIT_RATE(115200), .ID(32'h12345678)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx),
        .sck(sck), .cs(cs), .mosi(mosi), .miso(miso), .rw(rw), .intr(intr),
        .clk_core(clk_core), .reset_core(reset_core),
        .core_read_memory(core_read_memory), .core_write_memory(core_write_memory),
        .core_address_memory(core_address_memory), .core_write_data_memory(core_write_data_memory),
        .core_read_data_memory(core_read_data_memory), .core_memory_response(core_memory_response),
        .core_read_data_memory_sync(core_read_data_memory_sync),
        .core_memory_read_response_sync(core_memory_read_response_sync),
        .core_memory_write_response_sync(core_memory_write_response_sync),
        .core_read_memory_data(core_read_memory_data), .core_write_memory_data(core_write_memory_data),
        .core_address_memory_data(core_address_memory_data),
        .core_write_data_memory_data(core_write_data_memory_data),
        .core_read_data_memory_data(core_read_data_memory_data),
        .core_memory_response_data(core_memory_response_data)
    );

    int         checks = 0;
    int         errors = 0;
    int         core_edges = 0;
    bit         mon_on = 1'b1;
    logic [7:0] exp_q [$];
    logic [7:0] mon_byte;

    always @(posedge clk_core) core_edges++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Decodes every tx frame at mid-bit and scores it against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (4) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    mon_byte[i] = tx;
                end
                repeat (10) @(negedge clk);
                if (mon_on) begin
                    chk("tx_stop", 32'(tx), 32'd1);
                    if (exp_q.size() == 0) chk("tx_extra", 32'(mon_byte), 32'h100);
                    else                   chk("tx_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk) rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (10) @(negedge clk);
        end
        rx = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic expect_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int hi, lows, e0, n;
        reset = 1'b1; rx = 1'b1; sck = 1'b0; cs = 1'b0; mosi = 1'b0; rw = 1'b0;
        core_read_memory = 1'b0; core_write_memory = 1'b0;
        core_address_memory = '0; core_write_data_memory = '0;
        core_read_memory_data = 1'b0; core_write_memory_data = 1'b0;
        core_address_memory_data = '0; core_write_data_memory_data = '0;

        repeat (3) @(negedge clk);
        @(posedge clk) #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_clk_core", 32'(clk_core), 32'd0);
        chk("rst_reset_core", 32'(reset_core), 32'd1);
        chk("rst_i_rdata", core_read_data_memory, 32'd0);
        chk("rst_i_resp", 32'(core_memory_response), 32'd0);
        chk("rst_d_rdata", core_read_data_memory_data, 32'd0);
        chk("rst_d_resp", 32'(core_memory_response_data), 32'd0);
        chk("rst_miso_intr", 32'({miso, intr}), 32'd0);

        @(negedge clk) reset = 1'b0;
        hi = 0;
        repeat (30) begin
            @(posedge clk) #1;
            if (reset_core) hi++;
        end
        chk("reset_core_len", 32'(hi), 32'd20);
        chk("no_core_edges", 32'(core_edges), 32'd0);

        // Host write then readback
        send_byte(8'h57); send_word(32'h10); send_word(32'hDEADBEEF);
        exp_q.push_back(8'h06);
        send_byte(8'h4C); send_word(32'h10);
        expect_word(32'hDEADBEEF);
        drain();

        // Single-step N=5 and N=0
        e0 = core_edges;
        send_byte(8'h43); send_word(32'd5);
        exp_q.push_back(8'h06);
        drain();
        chk("step5_edges", 32'(core_edges - e0), 32'd5);
        e0 = core_edges;
        send_byte(8'h43); send_word(32'd0);
        exp_q.push_back(8'h06);
        drain();
        chk("step0_edges", 32'(core_edges - e0), 32'd0);

        // ID, ignored byte, then a command that must still work
        send_byte(8'h49); expect_word(32'h12345678);
        send_byte(8'hFF);
        send_byte(8'h50); exp_q.push_back(8'h06);
        drain();

        // Core running: instruction port reads 0x10, data port reads wrapped 0x1010
        core_address_memory = 32'h10; core_read_memory = 1'b1;
        core_address_memory_data = 32'h1010; core_read_memory_data = 1'b1;
        send_byte(8'h53); exp_q.push_back(8'h06);
        drain();
        @(negedge clk);
        chk("i_sync_data", core_read_data_memory_sync, 32'hDEADBEEF);
        chk("i_sync_rd", 32'(core_memory_read_response_sync), 32'd1);
        chk("i_sync_wr", 32'(core_memory_write_response_sync), 32'd0);
        @(posedge clk) #1;
        chk("i_rdata", core_read_data_memory, 32'hDEADBEEF);
        chk("i_resp", 32'(core_memory_response), 32'd1);
        chk("d_rdata_wrap", core_read_data_memory_data, 32'hDEADBEEF);
        chk("d_resp", 32'(core_memory_response_data), 32'd1);
        @(negedge clk);
        core_read_memory = 1'b0; core_read_memory_data = 1'b0;
        @(posedge clk) #1;
        chk("i_resp_drop", 32'(core_memory_response), 32'd0);
        chk("d_resp_drop", 32'(core_memory_response_data), 32'd0);

        // Same-word write collision, data port must win
        @(negedge clk);
        core_write_memory = 1'b1; core_address_memory = 32'h20; core_write_data_memory = 32'h11111111;
        core_write_memory_data = 1'b1; core_address_memory_data = 32'h20;
        core_write_data_memory_data = 32'h22222222;
        chk("i_sync_wr_strobe", 32'(core_memory_write_response_sync), 32'd1);
        @(negedge clk);
        core_write_memory = 1'b0; core_write_memory_data = 1'b0;

        send_byte(8'h50); exp_q.push_back(8'h06);
        drain();
        e0 = core_edges;
        repeat (50) @(negedge clk);
        chk("stopped_edges", 32'(core_edges - e0), 32'd0);
        send_byte(8'h4C); send_word(32'h20);   expect_word(32'h22222222);
        send_byte(8'h4C); send_word(32'h1010); expect_word(32'hDEADBEEF);
        drain();

        // Reset in the middle of an 'L' reply
        mon_on = 1'b0;
        send_byte(8'h4C); send_word(32'h10);
        n = 0;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reply_started", 32'(tx), 32'd0);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_reset_core", 32'(reset_core), 32'd1);
        chk("abort_clk_core", 32'(clk_core), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lows = 0;
        e0 = core_edges;
        repeat (400) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
        chk("fifo_flushed", 32'(lows), 32'd0);
        chk("abort_no_edges", 32'(core_edges - e0), 32'd0);
        mon_on = 1'b1;

        // Commands still work and memory survives reset
        send_byte(8'h49); expect_word(32'h12345678);
        send_byte(8'h4C); send_word(32'h10); expect_word(32'hDEADBEEF);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
